// File: rtl/exp_pkg.sv
// Shared definitions for the exponentiation (Taylor-series e^x) block:
// controller state encodings and default sizing.
package exp_pkg;

  localparam int STATE_W          = 3;
  localparam int NUM_OF_TERMS_DEF = 8;
  localparam int CNT_WIDTH_DEF    = 4;

  typedef enum logic [STATE_W-1:0] {
    RESET            = 3'd0,
    WAIT_ON_START    = 3'd1,
    CALC_NEXT_TERM_1 = 3'd2,
    CALC_NEXT_TERM_2 = 3'd3,
    ADD_NEXT_TERM    = 3'd4,
    CALC_COMPLETE    = 3'd5
  } state_t;

endpackage

// File: rtl/exponentiation_module_controller.sv
// Control FSM for the e^x datapath: clears, initialises and then steps the
// term/result registers once per series term until the counter terminates.
module exponentiation_module_controller
  import exp_pkg::*;
#(
  parameter int NUM_OF_TERMS = NUM_OF_TERMS_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 rstExponent,
  output logic                 rstTerm,
  output logic                 rstResultRegs,
  output logic                 rstCounter,
  output logic                 loadExponent,
  output logic                 initTerm,
  output logic                 initResultRegs,
  output logic                 initCounter,
  output logic                 loadTerm,
  output logic                 selTableData,
  output logic                 loadResultRegs,
  output logic                 incCounter
);

  if (NUM_OF_TERMS < 2 || NUM_OF_TERMS > (2**CNT_WIDTH) - 1) begin : g_bad_terms
    $error("NUM_OF_TERMS must lie in 2..2^CNT_WIDTH-1");
  end

  state_t p_state;
  state_t n_state;
  logic   last_term;

  // The counter still holds the pre-increment value while in ADD_NEXT_TERM.
  assign last_term = (cnt == CNT_WIDTH'(NUM_OF_TERMS - 1));

  always_ff @(posedge clk) begin
    if (!rst) p_state <= RESET;
    else      p_state <= n_state;
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no branch
    // below can leave one unassigned and infer a latch.
    n_state        = p_state;
    busy           = 1'b0;
    done           = 1'b0;
    rstExponent    = 1'b0;
    rstTerm        = 1'b0;
    rstResultRegs  = 1'b0;
    rstCounter     = 1'b0;
    loadExponent   = 1'b0;
    initTerm       = 1'b0;
    initResultRegs = 1'b0;
    initCounter    = 1'b0;
    loadTerm       = 1'b0;
    selTableData   = 1'b0;
    loadResultRegs = 1'b0;
    incCounter     = 1'b0;

    case (p_state)
      WAIT_ON_START: begin
        if (start) begin
          loadExponent   = 1'b1;
          initTerm       = 1'b1;
          initResultRegs = 1'b1;
          initCounter    = 1'b1;
          n_state        = CALC_NEXT_TERM_1;
        end
      end
      CALC_NEXT_TERM_1: begin
        busy     = 1'b1;
        loadTerm = 1'b1;
        n_state  = CALC_NEXT_TERM_2;
      end
      CALC_NEXT_TERM_2: begin
        busy         = 1'b1;
        loadTerm     = 1'b1;
        selTableData = 1'b1;
        n_state      = ADD_NEXT_TERM;
      end
      ADD_NEXT_TERM: begin
        busy           = 1'b1;
        loadResultRegs = 1'b1;
        incCounter     = 1'b1;
        n_state        = last_term ? CALC_COMPLETE : CALC_NEXT_TERM_1;
      end
      CALC_COMPLETE: begin
        done    = 1'b1;
        n_state = WAIT_ON_START;
      end
      default: begin
        rstExponent   = 1'b1;
        rstTerm       = 1'b1;
        rstResultRegs = 1'b1;
        rstCounter    = 1'b1;
        n_state       = WAIT_ON_START;
      end
    endcase

    // Reset clears the datapath on the same edge that resets the FSM.
    if (!rst) begin
      busy           = 1'b0;
      done           = 1'b0;
      rstExponent    = 1'b1;
      rstTerm        = 1'b1;
      rstResultRegs  = 1'b1;
      rstCounter     = 1'b1;
      loadExponent   = 1'b0;
      initTerm       = 1'b0;
      initResultRegs = 1'b0;
      initCounter    = 1'b0;
      loadTerm       = 1'b0;
      selTableData   = 1'b0;
      loadResultRegs = 1'b0;
      incCounter     = 1'b0;
      n_state        = RESET;
    end
  end

endmodule

// File: tb/tb_exponentiation_module_controller.sv
// Self-checking bench for the e^x controller: table-driven per-cycle strobe
// vectors through a scoreboard queue, plus hand-written corner sequences.
module tb_exponentiation_module_controller;

  // Output vector order: {busy, done, rst x4, init/load x4, loadTerm, sel, loadRes, inc}
  localparam logic [13:0] O_IDLE   = 14'b00_0000_0000_0000;
  localparam logic [13:0] O_RST    = 14'b00_1111_0000_0000;
  localparam logic [13:0] O_ACCEPT = 14'b00_0000_1111_0000;
  localparam logic [13:0] O_C1     = 14'b10_0000_0000_1000;
  localparam logic [13:0] O_C2     = 14'b10_0000_0000_1100;
  localparam logic [13:0] O_ADD    = 14'b10_0000_0000_0011;
  localparam logic [13:0] O_DONE   = 14'b01_0000_0000_0000;

  typedef struct {
    logic        rst;
    logic        start;
    logic [13:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, start_a = 1'b0, rst_b = 1'b0, start_b = 1'b0;
  logic [3:0] cnt_a = '0, cnt_b = '0;
  logic busy_a, done_a, rst_exp_a, rst_term_a, rst_res_a, rst_cnt_a;
  logic load_exp_a, init_term_a, init_res_a, init_cnt_a;
  logic load_term_a, sel_a, load_res_a, inc_a;
  logic busy_b, done_b, rst_exp_b, rst_term_b, rst_res_b, rst_cnt_b;
  logic load_exp_b, init_term_b, init_res_b, init_cnt_b;
  logic load_term_b, sel_b, load_res_b, inc_b;
  logic [13:0] out_a, out_b;

  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0;
  logic [13:0] exp_q[$];
  vec_t tbl[$];

  exponentiation_module_controller #(.NUM_OF_TERMS(8), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .cnt(cnt_a),
    .busy(busy_a), .done(done_a),
    .rstExponent(rst_exp_a), .rstTerm(rst_term_a),
    .rstResultRegs(rst_res_a), .rstCounter(rst_cnt_a),
    .loadExponent(load_exp_a), .initTerm(init_term_a),
    .initResultRegs(init_res_a), .initCounter(init_cnt_a),
    .loadTerm(load_term_a), .selTableData(sel_a),
    .loadResultRegs(load_res_a), .incCounter(inc_a)
  );

  exponentiation_module_controller #(.NUM_OF_TERMS(2), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .cnt(cnt_b),
    .busy(busy_b), .done(done_b),
    .rstExponent(rst_exp_b), .rstTerm(rst_term_b),
    .rstResultRegs(rst_res_b), .rstCounter(rst_cnt_b),
    .loadExponent(load_exp_b), .initTerm(init_term_b),
    .initResultRegs(init_res_b), .initCounter(init_cnt_b),
    .loadTerm(load_term_b), .selTableData(sel_b),
    .loadResultRegs(load_res_b), .incCounter(inc_b)
  );

  assign out_a = {busy_a, done_a, rst_exp_a, rst_term_a, rst_res_a, rst_cnt_a,
                  load_exp_a, init_term_a, init_res_a, init_cnt_a,
                  load_term_a, sel_a, load_res_a, inc_a};
  assign out_b = {busy_b, done_b, rst_exp_b, rst_term_b, rst_res_b, rst_cnt_b,
                  load_exp_b, init_term_b, init_res_b, init_cnt_b,
                  load_term_b, sel_b, load_res_b, inc_b};

  // Behavioural term counter standing in for the datapath.
  always @(posedge clk) begin
    if (rst_cnt_a)       cnt_a <= '0;
    else if (init_cnt_a) cnt_a <= 4'd1;
    else if (inc_a)      cnt_a <= cnt_a + 4'd1;
    if (rst_cnt_b)       cnt_b <= '0;
    else if (init_cnt_b) cnt_b <= 4'd1;
    else if (inc_b)      cnt_b <= cnt_b + 4'd1;
    if (done_a)          done_cnt_a <= done_cnt_a + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic [13:0] e, input string n);
    vec_t v;
    v.rst = r; v.start = s; v.exp = e; v.name = n;
    return v;
  endfunction

  function automatic logic [13:0] loop_exp(input int phase);
    case (phase % 3)
      0:       return O_C1;
      1:       return O_C2;
      default: return O_ADD;
    endcase
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare on the falling edge.
  task automatic apply_a(input logic r, input logic s, input logic [13:0] e, input string n);
    rst_a = r;
    start_a = s;
    exp_q.push_back(e);
    @(negedge clk);
    check(n, {18'd0, out_a}, {18'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_b(input logic r, input logic s, input logic [13:0] e, input string n);
    rst_b = r;
    start_b = s;
    exp_q.push_back(e);
    @(negedge clk);
    check(n, {18'd0, out_b}, {18'd0, exp_q.pop_front()});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    @(posedge clk);
    #1;

    // Reset, release, then a nominal 7-iteration run.
    tbl.push_back(mk(1'b0, 1'b0, O_RST,    "reset_forced"));
    tbl.push_back(mk(1'b1, 1'b0, O_RST,    "reset_state"));
    tbl.push_back(mk(1'b1, 1'b1, O_ACCEPT, "accept"));
    for (int i = 0; i < 21; i++) tbl.push_back(mk(1'b1, 1'b0, loop_exp(i), "nominal_loop"));
    tbl.push_back(mk(1'b1, 1'b0, O_DONE, "nominal_done"));
    tbl.push_back(mk(1'b1, 1'b0, O_IDLE, "nominal_idle"));
    // start held for 40 cycles: two runs, start ignored while busy/complete.
    base = tbl.size();
    for (int i = 0; i < 47; i++) begin
      logic [13:0] e;
      if (i == 0 || i == 23)           e = O_ACCEPT;
      else if (i >= 1 && i <= 21)      e = loop_exp(i - 1);
      else if (i == 22 || i == 45)     e = O_DONE;
      else if (i >= 24 && i <= 44)     e = loop_exp(i - 24);
      else                             e = O_IDLE;
      tbl.push_back(mk(1'b1, (i < 40), e, "held_start"));
    end

    for (int i = 0; i < base; i++) apply_a(tbl[i].rst, tbl[i].start, tbl[i].exp, tbl[i].name);
    check("cnt_after_done", {28'd0, cnt_a}, 32'd8);
    check("done_count_nominal", done_cnt_a, 32'd1);
    for (int i = base; i < tbl.size(); i++) apply_a(tbl[i].rst, tbl[i].start, tbl[i].exp, tbl[i].name);
    check("done_count_held", done_cnt_a, 32'd3);

    // Reset mid-run at loop cycle 10: no done pulse for the aborted run.
    apply_a(1'b1, 1'b1, O_ACCEPT, "abort_accept");
    for (int i = 0; i < 9; i++) apply_a(1'b1, 1'b0, loop_exp(i), "abort_loop");
    apply_a(1'b0, 1'b0, O_RST, "abort_forced");
    apply_a(1'b1, 1'b0, O_RST, "abort_reset_state");
    for (int i = 0; i < 25; i++) apply_a(1'b1, 1'b0, O_IDLE, "abort_idle");
    check("done_count_abort", done_cnt_a, 32'd3);

    // Latency from acceptance to done, with a bounded wait.
    rst_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done_a) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("done_latency", lat, 32'd22);
    @(posedge clk);
    #1;
    apply_a(1'b1, 1'b0, O_IDLE, "latency_idle");

    // NUM_OF_TERMS=2: one iteration, done 4 cycles after acceptance.
    apply_b(1'b1, 1'b0, O_RST,    "t2_reset_state");
    apply_b(1'b1, 1'b1, O_ACCEPT, "t2_accept");
    apply_b(1'b1, 1'b0, O_C1,     "t2_c1");
    apply_b(1'b1, 1'b0, O_C2,     "t2_c2");
    apply_b(1'b1, 1'b0, O_ADD,    "t2_add");
    apply_b(1'b1, 1'b0, O_DONE,   "t2_done");
    apply_b(1'b1, 1'b0, O_IDLE,   "t2_idle");
    check("t2_cnt_after_done", {28'd0, cnt_b}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
